// File: rtl/save_state_mem_arbiter.sv
// Round-robin arbiter sharing one memory port between the save-state manager (A) and bridge staging (B).
// Optional mem_ack watchdog enabled by defining SS_ARB_TIMEOUT_EN.
module save_state_mem_arbiter #(
    parameter int unsigned ADDR_W         = 26,
    parameter int unsigned DATA_W         = 64,
    parameter int unsigned TIMEOUT_CYCLES = 4096
) (
    input  logic                  clk_mem_85_9,
    input  logic                  reset_n,

    input  logic                  a_req,
    input  logic                  a_rnw,
    input  logic [ADDR_W-1:0]     a_addr,
    input  logic [DATA_W/8-1:0]   a_be,
    input  logic [DATA_W-1:0]     a_wdata,
    input  logic                  a_lock,
    output logic                  a_ack,
    output logic [DATA_W-1:0]     a_rdata,

    input  logic                  b_req,
    input  logic                  b_rnw,
    input  logic [ADDR_W-1:0]     b_addr,
    input  logic [DATA_W/8-1:0]   b_be,
    input  logic [DATA_W-1:0]     b_wdata,
    output logic                  b_ack,
    output logic [DATA_W-1:0]     b_rdata,

    output logic                  mem_req,
    output logic                  mem_rnw,
    output logic [ADDR_W-1:0]     mem_addr,
    output logic [DATA_W/8-1:0]   mem_be,
    output logic [DATA_W-1:0]     mem_wdata,
    input  logic                  mem_ack,
    input  logic [DATA_W-1:0]     mem_rdata,

    output logic                  arb_err
);

    localparam logic [1:0] IDLE     = 2'd0;
    localparam logic [1:0] ISSUE    = 2'd1;
    localparam logic [1:0] WAIT_ACK = 2'd2;
    localparam logic [1:0] RESP     = 2'd3;

    localparam logic SIDE_A = 1'b0;
    localparam logic SIDE_B = 1'b1;

    if (TIMEOUT_CYCLES < 2 || (DATA_W % 8) != 0) begin : g_cfg_check
        $error("save_state_mem_arbiter: unsupported TIMEOUT_CYCLES or DATA_W");
    end

    logic [1:0] state;
    logic [1:0] state_nxt;
    logic       grant;
    logic       last_grant;
    logic       grant_nxt;
    logic       elig_b;
    logic       start;
    logic       done;
    logic       expire;

    // State register
    always_ff @(posedge clk_mem_85_9 or negedge reset_n) begin
        if (!reset_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next state and arbitration decision
    always_comb begin
        state_nxt = state;
        grant_nxt = SIDE_A;
        start     = 1'b0;
        done      = 1'b0;
        elig_b    = b_req & ~a_lock;
        case (state)
            IDLE: begin
                if (a_req || elig_b) begin
                    start     = 1'b1;
                    state_nxt = ISSUE;
                    if (a_req && elig_b) begin
                        grant_nxt = ~last_grant;
                    end else begin
                        grant_nxt = a_req ? SIDE_A : SIDE_B;
                    end
                end
            end
            ISSUE:    state_nxt = WAIT_ACK;
            WAIT_ACK: begin
                if (mem_ack || expire) begin
                    done      = 1'b1;
                    state_nxt = RESP;
                end
            end
            RESP:     state_nxt = IDLE;
            default:  state_nxt = IDLE;
        endcase
    end

    // Request latch, memory handshake and per-port responses
    always_ff @(posedge clk_mem_85_9 or negedge reset_n) begin
        if (!reset_n) begin
            grant      <= SIDE_A;
            last_grant <= SIDE_B;
            mem_req    <= 1'b0;
            mem_rnw    <= 1'b0;
            mem_addr   <= '0;
            mem_be     <= '0;
            mem_wdata  <= '0;
            a_ack      <= 1'b0;
            b_ack      <= 1'b0;
            a_rdata    <= '0;
            b_rdata    <= '0;
        end else begin
            a_ack <= 1'b0;
            b_ack <= 1'b0;
            if (start) begin
                grant     <= grant_nxt;
                mem_rnw   <= (grant_nxt == SIDE_B) ? b_rnw   : a_rnw;
                mem_addr  <= (grant_nxt == SIDE_B) ? b_addr  : a_addr;
                mem_be    <= (grant_nxt == SIDE_B) ? b_be    : a_be;
                mem_wdata <= (grant_nxt == SIDE_B) ? b_wdata : a_wdata;
            end
            if (state == ISSUE) begin
                mem_req <= 1'b1;
            end
            if (done) begin
                mem_req    <= 1'b0;
                last_grant <= grant;
                // A watchdog abort returns zero read data
                if (grant == SIDE_B) begin
                    b_ack <= 1'b1;
                    if (mem_rnw) b_rdata <= mem_ack ? mem_rdata : '0;
                end else begin
                    a_ack <= 1'b1;
                    if (mem_rnw) a_rdata <= mem_ack ? mem_rdata : '0;
                end
            end
        end
    end

`ifdef SS_ARB_TIMEOUT_EN
    localparam int unsigned CNT_W = ($clog2(TIMEOUT_CYCLES + 1) > 13) ? $clog2(TIMEOUT_CYCLES + 1) : 13;

    logic [CNT_W-1:0] wd_cnt;

    // Watchdog on mem_ack; a same-cycle mem_ack takes priority over expiry
    always_ff @(posedge clk_mem_85_9 or negedge reset_n) begin
        if (!reset_n) begin
            wd_cnt  <= '0;
            arb_err <= 1'b0;
        end else begin
            arb_err <= expire & ~mem_ack;
            if (state == ISSUE) begin
                wd_cnt <= '0;
            end else if (state == WAIT_ACK) begin
                wd_cnt <= wd_cnt + CNT_W'(1);
            end
        end
    end

    assign expire = (state == WAIT_ACK) && (wd_cnt == CNT_W'(TIMEOUT_CYCLES - 1));
`else
    assign expire  = 1'b0;
    assign arb_err = 1'b0;
`endif

endmodule
